data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory target for the pipelined core's memory stage. It is the responder end of the M-stage load/store request.
- Accepts one word request at a time and completes it after a fixed latency.
- Drives a stall back to the hazard logic so that StallF/StallD hold the front end and the M-stage request stays stable until completion.
- Replaces the single-cycle data memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit storage words (power of two).
- LATENCY, 2, cycles from acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  memory stage holds a load or store (MemWriteM, or ResultSrcM==01).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALUResultM).
- req_wdata  in  32  store data (WriteDataM).
- req_be  in  4  byte enables for stores; ignored for loads.
- mem_stall  out  1  to hazard logic; freeze F/D/E/M while high.
- resp_valid  out  1  one-cycle pulse: access completed this cycle.
- resp_rdata  out  32  load data; valid when resp_valid=1.
- resp_err  out  1  misaligned access; pulses with resp_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, capture registers = 0.
  - mem_stall = 0 while rst=0.
  - Storage array is not cleared.
- States are IDLE, WAIT and DONE.
- IDLE:
  - mem_stall = req_valid (combinational).
  - On req_valid=1, capture write, addr, wdata and be. Load counter with LATENCY-1.
  - Go to DONE if LATENCY==1, else WAIT.
- WAIT:
  - mem_stall = 1. Counter decrements each cycle.
  - When counter==1, the next state is DONE.
  - req inputs are ignored; the pipeline holds them stable.
- DONE:
  - Access is performed on the clock edge that enters DONE.
  - resp_valid = 1 and mem_stall = 0 for exactly this cycle, so the pipeline advances.
  - req_valid is ignored in DONE; it still shows the completing request.
  - Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle t gives resp_valid at t+LATENCY.
  - mem_stall is high for cycles t..t+LATENCY-1 (exactly LATENCY cycles).
  - Back-to-back requests: a new request can be accepted in the IDLE cycle right after DONE, with no bubble.
- Read: resp_rdata = mem[index], registered. It holds its value until the next DONE; it is not zeroed between responses.
- Write:
  - For each byte i with be[i]=1, write mem[index] byte i from wdata byte i.
  - Bytes with be[i]=0 are unchanged. be=0000 is a legal no-op.
  - resp_rdata is unchanged on a write.
- Indexing:
  - index = addr[log2(DEPTH_WORDS)+1 : 2].
  - Upper address bits are ignored, so out-of-range addresses alias (wrap) with no error.
- Misalignment (addr[1:0] != 00, loads and stores):
  - resp_err = 1 in DONE.
  - Store is suppressed (no array change).
  - Load returns resp_rdata = 0.
  - Same latency as an aligned access.
- Reset mid-operation (rst=0 during WAIT or before DONE): the pending access is dropped, including a store. The array keeps its prior contents.
- Simultaneous events: the DONE cycle never accepts a request. A request arriving in IDLE always starts a new access.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, WAIT=2'b01, DONE=2'b10;
  - WORD_W=32 and BE_W=4.
- One sub-module is natural: data_mem_array.
  - Synchronous storage with byte-enable write and registered read.
  - Instanced once.
- The FSM and counter stay in data_mem_responder.

Test Plan:
- Reset check, LATENCY=2:
  - Stimulus: assert rst=0 mid-cycle.
  - Response: all outputs go to 0 immediately, without waiting for a clk edge.
  - Stimulus: release rst, then req_valid=0 for 3 cycles.
  - Response: mem_stall=0 and resp_valid=0 throughout.
- Aligned store then load, LATENCY=2:
  - Stimulus: store 0xDEADBEEF to 0x10, be=1111.
  - Response: mem_stall high for 2 cycles; resp_valid at t+2.
  - Stimulus: load from 0x10.
  - Response: resp_rdata=0xDEADBEEF at t+2; resp_err=0.
- Byte-enable merge:
  - Stimulus: store 0x11223344 to 0x20, be=1111; then store 0xAABBCCDD to 0x20, be=0101; then load 0x20.
  - Response: resp_rdata=0x11BB33DD.
- Misaligned access:
  - Stimulus: store 0xFFFFFFFF to 0x21.
  - Response: resp_err=1 with resp_valid.
  - Stimulus: load from 0x20.
  - Response: resp_rdata=0x11BB33DD (array unchanged).
  - Stimulus: load from 0x22.
  - Response: resp_rdata=0, resp_err=1.
- Back-to-back and wrap, LATENCY=1, DEPTH_WORDS=1024:
  - Stimulus: store 0x5 to 0x0, then immediately load from 0x1000.
  - Response: the load is accepted in the cycle after DONE and returns 0x5 (alias).
  - Response: mem_stall is high 1 cycle per access.
- Reset mid-store, LATENCY=4:
  - Stimulus: store 0x77 to 0x40, pulse rst=0 during WAIT, then load from 0x40.
  - Response: the load returns the previous contents, not 0x77.
  - Response: no resp_valid is ever produced for the aborted store.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // FSM encoding is fixed so the state is easy to read on a waveform.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  // Only word-aligned accesses are serviced; anything else reports an error.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// M-stage request / response bundle between the core and the data memory.
// Latency: n/a (wiring only).
// Backpressure: mem_stall from the slave holds the master's request stable.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              mem_stall;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  mem_stall, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output mem_stall, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder_array.sv
// Word storage with per-byte write enables and a registered read port.
// Latency: read data appears one clock after en_i.
// Backpressure: none; accepts an access whenever en_i is high.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              misalign_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Byte-masked store; the array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (en_i && we_i && !misalign_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Load data register: updated only by loads, zero for a misaligned load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= misalign_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the M stage: one word access at a time.
// Latency: resp_valid LATENCY cycles after the request is seen in IDLE.
// Backpressure: mem_stall high from acceptance until the DONE cycle.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,  // power of two
  parameter int LATENCY     = 2      // 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              accept;
  logic              stall;
  logic              resp_vld;
  logic              fire;
  logic              use_live;
  logic              acc_write;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              unused_addr_hi;

  // State, counter and request capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    stall    = 1'b0;
    resp_vld = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.req_valid;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a corrupted counter cannot wedge the FSM.
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Request inputs still show the completing access; never re-accept.
        resp_vld = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With LATENCY==1 the access fires on the accepting edge, before the
  // capture registers hold the request, so take it straight from the bus.
  assign use_live  = (state_q == IDLE);
  assign acc_write = use_live ? bus.req_write : wr_q;
  assign acc_addr  = use_live ? bus.req_addr  : addr_q;
  assign acc_wdata = use_live ? bus.req_wdata : wdata_q;
  assign acc_be    = use_live ? bus.req_be    : be_q;

  // The array is touched only on the edge that enters DONE; gating with rst
  // keeps a request present during reset from reaching the storage.
  assign fire = rst && (state_d == DONE) && (state_q != DONE);

  // Upper address bits alias by design.
  assign unused_addr_hi = ^acc_addr[WORD_W-1:AW+2];

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .en_i       (fire),
    .we_i       (acc_write),
    .misalign_i (is_misaligned(acc_addr[1:0])),
    .idx_i      (acc_addr[AW+1:2]),
    .wdata_i    (acc_wdata),
    .be_i       (acc_be),
    .rdata_o    (bus.resp_rdata)
  );

  assign bus.mem_stall  = rst && stall;
  assign bus.resp_valid = resp_vld;
  assign bus.resp_err   = resp_vld && is_misaligned(addr_q[1:0]);

endmodule
